// File: rtl/debug_gpio_mux.sv
// -----------------------------------------------------------------------------
// debug_gpio_mux
//
// Purpose:
//   Drives N_GPIO debug pins. Each pin picks one internal observation source
//   (status bit, index match, PWM channel or a direct bit), registers it, and
//   then conditions it with a per-pin mode so that single-cycle events are
//   visible on a scope or an LED:
//     LEVEL   : pin follows the selected source (2-cycle latency)
//     STRETCH : each rising edge holds the pin high for max(DBG_STRETCH,1)
//               cycles; a retrigger reloads the count (3-cycle latency)
//     STICKY  : first rising edge latches the pin high until cleared
//     TOGGLE  : each rising edge inverts the pin
//   Changing a pin's {type, value, mode} clears that pin's conditioning state
//   and blanks its output for one cycle. DBG_CLEAR clears the conditioning
//   state of every pin; LEVEL pins are unaffected by it.
//   Runs in the PWM clock domain.
//
// Ports:
//   CLK, RST_N          clock, asynchronous active-low reset
//   DBG_TYPE[N_GPIO]    per-pin source select (params::DBG_* encoding)
//   DBG_VALUE[N_GPIO]   per-pin source argument (index, PWM channel, bit)
//   DBG_MODE[N_GPIO]    per-pin mode (params::dbg_mode_e)
//   DBG_STRETCH[N_GPIO] per-pin pulse-stretch length in cycles
//   DBG_CLEAR           one-cycle pulse clearing stretch/sticky/toggle state
//   TIME_CNT            PWM time counter
//   PWM_OUT             transducer PWM outputs, one bit per channel
//   THERMO, FORCE_FAN, SYNC, STM_SEGMENT, MOD_SEGMENT   status bits
//   STM_IDX, MOD_IDX    current STM / modulation indices
//   STM_CYCLE           STM cycle length; nonzero means STM mode
//   GPIO_OUT            conditioned debug outputs, one bit per pin
// -----------------------------------------------------------------------------

package params;

  localparam logic [7:0] DBG_NONE        = 8'h00;
  localparam logic [7:0] DBG_BASE_SIG    = 8'h01;
  localparam logic [7:0] DBG_THERMO      = 8'h02;
  localparam logic [7:0] DBG_FORCE_FAN   = 8'h03;
  localparam logic [7:0] DBG_SYNC        = 8'h10;
  localparam logic [7:0] DBG_MOD_SEGMENT = 8'h20;
  localparam logic [7:0] DBG_MOD_IDX     = 8'h21;
  localparam logic [7:0] DBG_STM_SEGMENT = 8'h50;
  localparam logic [7:0] DBG_STM_IDX     = 8'h51;
  localparam logic [7:0] DBG_IS_STM_MODE = 8'h52;
  localparam logic [7:0] DBG_PWM_OUT     = 8'hE0;
  localparam logic [7:0] DBG_DIRECT      = 8'hF0;

  typedef enum logic [1:0] {
    MODE_LEVEL   = 2'd0,
    MODE_STRETCH = 2'd1,
    MODE_STICKY  = 2'd2,
    MODE_TOGGLE  = 2'd3
  } dbg_mode_e;

endpackage

module debug_gpio_mux
  import params::*;
#(
  parameter int DEPTH     = 249,
  parameter int N_GPIO    = 4,
  parameter int STRETCH_W = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [7:0]           DBG_TYPE    [N_GPIO],
  input  logic [15:0]          DBG_VALUE   [N_GPIO],
  input  logic [1:0]           DBG_MODE    [N_GPIO],
  input  logic [STRETCH_W-1:0] DBG_STRETCH [N_GPIO],
  input  logic                 DBG_CLEAR,
  input  logic [8:0]           TIME_CNT,
  input  logic [DEPTH-1:0]     PWM_OUT,
  input  logic                 THERMO,
  input  logic                 FORCE_FAN,
  input  logic                 SYNC,
  input  logic                 STM_SEGMENT,
  input  logic                 MOD_SEGMENT,
  input  logic [12:0]          STM_IDX,
  input  logic [14:0]          MOD_IDX,
  input  logic [12:0]          STM_CYCLE,
  output logic [N_GPIO-1:0]    GPIO_OUT
);

  localparam int             IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [15:0]    DEPTH_V = 16'(DEPTH);
  localparam int             SET_W   = 8 + 16 + 2;

  // Only the half-period bit of the time counter is observable on a pin.
  logic unused_time_bits;
  assign unused_time_bits = ^TIME_CNT[7:0];

  for (genvar i = 0; i < N_GPIO; i++) begin : g_pin

    logic                 raw_q, raw_d;
    logic                 raw_prev_q, raw_prev_d;
    logic                 sticky_q, sticky_d;
    logic                 tgl_q, tgl_d;
    logic                 out_q, out_d;
    logic [STRETCH_W-1:0] cnt_q, cnt_d;
    logic [SET_W-1:0]     shadow_q, shadow_d;
    logic [STRETCH_W-1:0] reload;
    logic [IDX_W-1:0]     pwm_idx;
    logic                 chg, kill, rise;

    // Stage 1: source select.
    always_comb begin
      // NOTE: every combinational output gets a default first, so no path
      // through the case can leave it unassigned and infer a latch.
      raw_d   = 1'b0;
      pwm_idx = DBG_VALUE[i][IDX_W-1:0];
      case (DBG_TYPE[i])
        DBG_BASE_SIG:    raw_d = ~TIME_CNT[8];
        DBG_THERMO:      raw_d = THERMO;
        DBG_FORCE_FAN:   raw_d = FORCE_FAN;
        DBG_SYNC:        raw_d = SYNC;
        DBG_MOD_SEGMENT: raw_d = MOD_SEGMENT;
        DBG_STM_SEGMENT: raw_d = STM_SEGMENT;
        DBG_MOD_IDX:     raw_d = (MOD_IDX == DBG_VALUE[i][14:0]);
        DBG_STM_IDX:     raw_d = (STM_IDX == DBG_VALUE[i][12:0]);
        DBG_IS_STM_MODE: raw_d = (STM_CYCLE != 13'd0);
        DBG_DIRECT:      raw_d = DBG_VALUE[i][0];
        // Channels past the end read as 0 rather than an undefined bit.
        DBG_PWM_OUT:     raw_d = (DBG_VALUE[i] < DEPTH_V) ? PWM_OUT[pwm_idx] : 1'b0;
        default:         raw_d = 1'b0;
      endcase
    end

    // Stage 2: mode conditioning.
    always_comb begin
      shadow_d   = {DBG_TYPE[i], DBG_VALUE[i], DBG_MODE[i]};
      chg        = (shadow_d != shadow_q);
      kill       = chg | DBG_CLEAR;
      rise       = raw_q & ~raw_prev_q;
      reload     = (DBG_STRETCH[i] == '0) ? STRETCH_W'(1) : DBG_STRETCH[i];

      // A settings change forgets the old source's history, so the switch
      // itself cannot be mistaken for an edge of the new source.
      raw_prev_d = chg ? 1'b0 : raw_q;

      // Clear wins over a coincident rise: the edge is dropped.
      if (kill) begin
        cnt_d    = '0;
        sticky_d = 1'b0;
        tgl_d    = 1'b0;
      end else begin
        if (rise)             cnt_d = reload;
        else if (cnt_q != '0) cnt_d = cnt_q - STRETCH_W'(1);
        else                  cnt_d = '0;
        sticky_d = sticky_q | rise;
        tgl_d    = tgl_q ^ rise;
      end

      out_d = 1'b0;
      if (!chg) begin
        unique case (dbg_mode_e'(DBG_MODE[i]))
          MODE_LEVEL:   out_d = raw_q;
          MODE_STRETCH: out_d = ~DBG_CLEAR & (cnt_q != '0);
          MODE_STICKY:  out_d = ~DBG_CLEAR & sticky_q;
          MODE_TOGGLE:  out_d = ~DBG_CLEAR & tgl_q;
        endcase
      end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        raw_q      <= 1'b0;
        raw_prev_q <= 1'b0;
        cnt_q      <= '0;
        sticky_q   <= 1'b0;
        tgl_q      <= 1'b0;
        shadow_q   <= '0;
        out_q      <= 1'b0;
      end else begin
        // NOTE: non-blocking assignments so every flop samples the values
        // from before this edge, regardless of statement order.
        raw_q      <= raw_d;
        raw_prev_q <= raw_prev_d;
        cnt_q      <= cnt_d;
        sticky_q   <= sticky_d;
        tgl_q      <= tgl_d;
        shadow_q   <= shadow_d;
        out_q      <= out_d;
      end
    end

    assign GPIO_OUT[i] = out_q;

  end

endmodule

// File: tb/tb_debug_gpio_mux.sv
// -----------------------------------------------------------------------------
// tb_debug_gpio_mux
//
// Directed scenarios followed by a randomized run on an 8-pin build. A
// behavioural model predicts every pin every cycle: stretch is tracked as an
// absolute deadline, toggle as rise parity, sticky as a flag, and settings
// changes by comparing against the previously applied settings.
// -----------------------------------------------------------------------------

module tb_debug_gpio_mux;
  import params::*;

  localparam int DEPTH = 249;
  localparam int N     = 8;
  localparam int SW    = 16;

  logic           clk;
  logic           rst_n;
  logic [7:0]     dbg_type    [N];
  logic [15:0]    dbg_value   [N];
  logic [1:0]     dbg_mode    [N];
  logic [SW-1:0]  dbg_stretch [N];
  logic           dbg_clear;
  logic [8:0]     time_cnt;
  logic [DEPTH-1:0] pwm_out;
  logic           thermo, force_fan, sync, stm_segment, mod_segment;
  logic [12:0]    stm_idx;
  logic [14:0]    mod_idx;
  logic [12:0]    stm_cycle;
  logic [N-1:0]   gpio_out;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  // Reference model state.
  int          edge_n;
  logic        m_raw    [N];
  logic        m_rp     [N];
  logic        m_sticky [N];
  logic        m_tog    [N];
  logic        m_exp    [N];
  int          m_end    [N];
  logic [25:0] m_shadow [N];

  debug_gpio_mux #(.DEPTH(DEPTH), .N_GPIO(N), .STRETCH_W(SW)) dut (
    .CLK(clk), .RST_N(rst_n),
    .DBG_TYPE(dbg_type), .DBG_VALUE(dbg_value), .DBG_MODE(dbg_mode),
    .DBG_STRETCH(dbg_stretch), .DBG_CLEAR(dbg_clear),
    .TIME_CNT(time_cnt), .PWM_OUT(pwm_out),
    .THERMO(thermo), .FORCE_FAN(force_fan), .SYNC(sync),
    .STM_SEGMENT(stm_segment), .MOD_SEGMENT(mod_segment),
    .STM_IDX(stm_idx), .MOD_IDX(mod_idx), .STM_CYCLE(stm_cycle),
    .GPIO_OUT(gpio_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Source table straight from the pin-select rules.
  function automatic logic src_bit(int p);
    logic [15:0] v;
    logic [7:0]  idx;
    v   = dbg_value[p];
    idx = v[7:0];
    case (dbg_type[p])
      DBG_BASE_SIG:    return time_cnt < 9'd256;
      DBG_THERMO:      return thermo;
      DBG_FORCE_FAN:   return force_fan;
      DBG_SYNC:        return sync;
      DBG_MOD_SEGMENT: return mod_segment;
      DBG_STM_SEGMENT: return stm_segment;
      DBG_MOD_IDX:     return mod_idx == v[14:0];
      DBG_STM_IDX:     return stm_idx == v[12:0];
      DBG_IS_STM_MODE: return stm_cycle != 13'd0;
      DBG_DIRECT:      return v[0];
      DBG_PWM_OUT:     return (v < 16'(DEPTH)) ? pwm_out[idx] : 1'b0;
      default:         return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    edge_n = 0;
    for (int p = 0; p < N; p++) begin
      m_raw[p] = 0; m_rp[p] = 0; m_sticky[p] = 0; m_tog[p] = 0;
      m_exp[p] = 0; m_end[p] = 0; m_shadow[p] = '0;
    end
  endtask

  // Called at each active edge with the inputs the DUT samples there;
  // produces the output expected just after that edge.
  task automatic model_step();
    edge_n++;
    for (int p = 0; p < N; p++) begin
      logic [25:0] s;
      logic chg, rise, active;
      int len;
      s      = {dbg_type[p], dbg_value[p], dbg_mode[p]};
      chg    = (s != m_shadow[p]);
      active = (edge_n - 1) < m_end[p];
      rise   = m_raw[p] & ~m_rp[p];
      len    = (dbg_stretch[p] == 0) ? 1 : int'(dbg_stretch[p]);
      if (chg) m_exp[p] = 1'b0;
      else begin
        case (dbg_mode[p])
          MODE_LEVEL:   m_exp[p] = m_raw[p];
          MODE_STRETCH: m_exp[p] = !dbg_clear && active;
          MODE_STICKY:  m_exp[p] = !dbg_clear && m_sticky[p];
          default:      m_exp[p] = !dbg_clear && m_tog[p];
        endcase
      end
      if (chg || dbg_clear) begin
        m_end[p] = 0; m_sticky[p] = 0; m_tog[p] = 0;
      end else if (rise) begin
        m_end[p] = edge_n + len; m_sticky[p] = 1; m_tog[p] = ~m_tog[p];
      end
      m_rp[p]     = chg ? 1'b0 : m_raw[p];
      m_raw[p]    = src_bit(p);
      m_shadow[p] = s;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    for (int p = 0; p < N; p++)
      check($sformatf("model_pin%0d_edge%0d", p, edge_n), gpio_out[p], m_exp[p]);
  endtask

  task automatic set_pin(input int p, input logic [7:0] t, input logic [15:0] v,
                         input logic [1:0] m, input logic [SW-1:0] s);
    dbg_type[p] = t; dbg_value[p] = v; dbg_mode[p] = m; dbg_stretch[p] = s;
  endtask

  function automatic logic [7:0] pick_type();
    case ($urandom_range(0, 13))
      0:  return DBG_NONE;
      1:  return DBG_BASE_SIG;
      2:  return DBG_THERMO;
      3:  return DBG_FORCE_FAN;
      4:  return DBG_SYNC;
      5:  return DBG_MOD_SEGMENT;
      6:  return DBG_MOD_IDX;
      7:  return DBG_STM_SEGMENT;
      8:  return DBG_STM_IDX;
      9:  return DBG_IS_STM_MODE;
      10: return DBG_PWM_OUT;
      11: return DBG_DIRECT;
      12: return 8'h0A;
      default: return 8'h77;
    endcase
  endfunction

  task automatic rand_pin(input int p);
    logic [7:0]  t;
    logic [15:0] v;
    t = pick_type();
    case (t)
      DBG_MOD_IDX, DBG_STM_IDX: v = 16'($urandom_range(0, 7));
      DBG_PWM_OUT:              v = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom_range(0, 255));
      default:                  v = 16'($urandom_range(0, 65535));
    endcase
    set_pin(p, t, v, 2'($urandom_range(0, 3)), SW'($urandom_range(0, 6)));
  endtask

  initial begin
    int hi, rises, last, nchg;
    logic prev;

    rst_n = 1'b0;
    for (int p = 0; p < N; p++) set_pin(p, DBG_NONE, 16'd0, MODE_LEVEL, '0);
    dbg_clear = 0; time_cnt = '0; pwm_out = '0;
    thermo = 0; force_fan = 0; sync = 0; stm_segment = 0; mod_segment = 0;
    stm_idx = '0; mod_idx = '0; stm_cycle = '0;
    model_reset();

    repeat (3) @(negedge clk);
    check("reset_state", gpio_out, 32'd0);
    rst_n = 1'b1;

    // LEVEL on a direct bit: one blank cycle, then high.
    set_pin(0, DBG_DIRECT, 16'd1, MODE_LEVEL, '0);
    tick(); check("level_blank", gpio_out[0], 1'b0);
    tick(); check("level_on", gpio_out[0], 1'b1);
    repeat (3) tick();

    // Asynchronous reset between edges.
    #2 rst_n = 1'b0;
    #1 check("async_reset", gpio_out, 32'd0);
    @(negedge clk); @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    tick(); tick(); check("level_after_reset", gpio_out[0], 1'b1);

    // Index-match stretch of 10, then minimum stretch.
    mod_idx = 15'd4;
    set_pin(1, DBG_MOD_IDX, 16'd5, MODE_STRETCH, SW'(10));
    repeat (3) tick();
    mod_idx = 15'd5; tick();
    mod_idx = 15'd6; tick(); check("stretch_latency2", gpio_out[1], 1'b0);
    tick(); check("stretch_latency3", gpio_out[1], 1'b1);
    hi = 1;
    repeat (20) begin tick(); hi += int'(gpio_out[1]); end
    check("stretch_len10", hi, 10);
    dbg_stretch[1] = '0;
    mod_idx = 15'd5; tick();
    mod_idx = 15'd4;
    hi = 0;
    repeat (10) begin tick(); hi += int'(gpio_out[1]); end
    check("stretch_len_zero", hi, 1);

    // Retrigger: two SYNC rises 4 cycles apart merge into 12 cycles.
    set_pin(4, DBG_SYNC, 16'd0, MODE_STRETCH, SW'(8));
    repeat (3) tick();
    hi = 0; rises = 0; prev = gpio_out[4];
    for (int k = 0; k < 30; k++) begin
      sync = (k == 0 || k == 4);
      tick();
      hi += int'(gpio_out[4]);
      if (gpio_out[4] && !prev) rises++;
      prev = gpio_out[4];
    end
    sync = 0;
    check("retrigger_len12", hi, 12);
    check("retrigger_one_pulse", rises, 1);

    // Sticky latch, clear, and clear coincident with a rise.
    stm_idx = 13'd3;
    set_pin(2, DBG_STM_IDX, 16'd0, MODE_STICKY, '0);
    repeat (3) tick(); check("sticky_idle", gpio_out[2], 1'b0);
    stm_idx = 13'd0; tick();
    stm_idx = 13'd1;
    repeat (8) tick(); check("sticky_hold", gpio_out[2], 1'b1);
    dbg_clear = 1; tick(); dbg_clear = 0;
    check("sticky_clear", gpio_out[2], 1'b0);
    check("clear_spares_level", gpio_out[0], 1'b1);
    repeat (2) tick();
    stm_idx = 13'd0; tick();
    stm_idx = 13'd1; dbg_clear = 1; tick(); dbg_clear = 0;
    repeat (6) tick(); check("clear_beats_rise", gpio_out[2], 1'b0);

    // Toggle on PWM channel 3: period 20 in, period 40 out.
    set_pin(3, DBG_PWM_OUT, 16'd3, MODE_TOGGLE, '0);
    repeat (3) tick();
    last = -1; nchg = 0; prev = gpio_out[3];
    for (int k = 0; k < 200; k++) begin
      pwm_out[3] = ((k % 20) < 10);
      tick();
      if (gpio_out[3] !== prev) begin
        if (last >= 0) check("toggle_half_period", k - last, 20);
        last = k; nchg++;
      end
      prev = gpio_out[3];
    end
    check("toggle_changes", nchg, 10);

    // Channel index equal to DEPTH reads as 0 even with every channel active.
    set_pin(3, DBG_PWM_OUT, 16'(DEPTH), MODE_LEVEL, '0);
    hi = 0;
    for (int k = 0; k < 60; k++) begin
      pwm_out = ((k % 20) < 10) ? '1 : '0;
      tick();
      hi += int'(gpio_out[3]);
    end
    check("pwm_out_of_range", hi, 0);
    pwm_out = '0;

    // Upper pins: independent sources; a change on pin5 blanks only pin5.
    thermo = 1; force_fan = 1; time_cnt = 9'd10; stm_cycle = 13'd7;
    set_pin(5, DBG_THERMO, 16'd0, MODE_LEVEL, '0);
    set_pin(6, DBG_BASE_SIG, 16'd0, MODE_LEVEL, '0);
    set_pin(7, DBG_IS_STM_MODE, 16'd0, MODE_STICKY, '0);
    repeat (4) tick();
    check("pin5_level", gpio_out[5], 1'b1);
    check("pin6_base_sig", gpio_out[6], 1'b1);
    check("pin7_sticky", gpio_out[7], 1'b1);
    set_pin(5, DBG_FORCE_FAN, 16'd0, MODE_LEVEL, '0);
    tick();
    check("pin5_blank", gpio_out[5], 1'b0);
    check("pin6_not_blanked", gpio_out[6], 1'b1);
    check("pin7_not_blanked", gpio_out[7], 1'b1);
    tick(); check("pin5_restored", gpio_out[5], 1'b1);

    // Randomized run against the model.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      thermo      = 1'($urandom_range(0, 1));
      force_fan   = 1'($urandom_range(0, 1));
      sync        = ($urandom_range(0, 3) == 0);
      stm_segment = 1'($urandom_range(0, 1));
      mod_segment = 1'($urandom_range(0, 1));
      stm_idx     = 13'($urandom_range(0, 7));
      mod_idx     = 15'($urandom_range(0, 7));
      stm_cycle   = ($urandom_range(0, 1) == 0) ? 13'd0 : 13'($urandom_range(1, 8191));
      time_cnt    = 9'($urandom_range(0, 511));
      for (int b = 0; b < DEPTH; b++) pwm_out[b] = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) rand_pin($urandom_range(0, N - 1));
      if ($urandom_range(0, 59) == 0) begin
        int q, r;
        q = $urandom_range(0, N - 1);
        r = $urandom_range(0, N - 1);
        set_pin(q, dbg_type[r], dbg_value[r], dbg_mode[r], dbg_stretch[r]);
      end
      if ($urandom_range(0, 49) == 0)
        dbg_stretch[$urandom_range(0, N - 1)] = SW'($urandom_range(0, 6));
      dbg_clear = ($urandom_range(0, 29) == 0);
      tick();
    end
    dbg_clear = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
